// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states,
// opcodes and the select/operation codes driven toward the datapath.
package riscv_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_EXECUTEI = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Per-state control bundle produced by the Moore output decode.
    typedef struct packed {
        logic       pcUpdate;
        logic       branch;
        logic       adrSrc;
        logic       memWrite;
        logic       irWrite;
        logic       regWrite;
        logic [1:0] resultSrc;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
    } ctrlSignals_t;

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU operation decoder shared with the single-cycle core: maps ALUOp plus
// instruction fields onto the ALU's operation select.
module aludec
    import riscv_pkg::*;
(
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] aluOp,
    output logic [2:0] aluControl
);

    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type with funct7[5] subtracts; addi never does.
                    3'b000:  aluControl = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControl = ALU_SLT;
                    3'b110:  aluControl = ALU_OR;
                    3'b111:  aluControl = ALU_AND;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, plus the immediate-format and ALU decoders.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic [3:0] state
);

    logic [3:0]   stateReg;
    logic [3:0]   nextState;
    logic [3:0]   curState;
    ctrlSignals_t ctrl;

    always_ff @(posedge clk) begin
        if (reset) stateReg <= S_FETCH;
        else       stateReg <= nextState;
    end

    always_comb begin
        nextState = S_FETCH;
        case (stateReg)
            S_FETCH: nextState = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nextState = S_MEMADR;
                    OP_R:         nextState = S_EXECUTER;
                    OP_I:         nextState = S_EXECUTEI;
                    OP_JAL:       nextState = S_JAL;
                    OP_BEQ:       nextState = S_BEQ;
                    default:      nextState = S_FETCH;
                endcase
            end
            S_MEMADR:   nextState = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  nextState = S_MEMWB;
            S_EXECUTER: nextState = S_ALUWB;
            S_EXECUTEI: nextState = S_ALUWB;
            S_JAL:      nextState = S_ALUWB;
            default:    nextState = S_FETCH;
        endcase
    end

    // While reset is high the outputs present FETCH values, strobes gated below.
    assign curState = reset ? S_FETCH : stateReg;

    always_comb begin
        ctrl = '0;
        case (curState)
            S_FETCH: begin
                ctrl.irWrite   = 1'b1;
                ctrl.aluSrcA   = SRCA_PC;
                ctrl.aluSrcB   = SRCB_FOUR;
                ctrl.aluOp     = ALUOP_ADD;
                ctrl.resultSrc = RES_ALURESULT;
                ctrl.pcUpdate  = 1'b1;
            end
            S_DECODE: begin
                ctrl.aluSrcA = SRCA_OLDPC;
                ctrl.aluSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ctrl.aluSrcA = SRCA_REG;
                ctrl.aluSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl.resultSrc = RES_ALUOUT;
                ctrl.adrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.resultSrc = RES_DATA;
                ctrl.regWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adrSrc   = 1'b1;
                ctrl.memWrite = 1'b1;
            end
            S_EXECUTER: begin
                ctrl.aluSrcA = SRCA_REG;
                ctrl.aluSrcB = SRCB_REG;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB: ctrl.regWrite = 1'b1;
            S_EXECUTEI: begin
                ctrl.aluSrcA = SRCA_REG;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            S_JAL: begin
                ctrl.aluSrcA  = SRCA_OLDPC;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.pcUpdate = 1'b1;
            end
            S_BEQ: begin
                ctrl.aluSrcA = SRCA_REG;
                ctrl.aluSrcB = SRCB_REG;
                ctrl.aluOp   = ALUOP_SUB;
                ctrl.branch  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    aludec uAludec (
        .opb5       (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .aluOp      (ctrl.aluOp),
        .aluControl (ALUControl)
    );

    assign PCWrite   = ~reset & (ctrl.pcUpdate | (ctrl.branch & Zero));
    assign IRWrite   = ~reset & ctrl.irWrite;
    assign MemWrite  = ~reset & ctrl.memWrite;
    assign RegWrite  = ~reset & ctrl.regWrite;
    assign AdrSrc    = ctrl.adrSrc;
    assign ResultSrc = ctrl.resultSrc;
    assign ALUSrcA   = ctrl.aluSrcA;
    assign ALUSrcB   = ctrl.aluSrcB;
    assign state     = stateReg;

endmodule
